// File: rtl/rx_fifo_arbiter.sv
// Receive FIFO arbiter: pops one word at a time and presents it to the Host or BIST requester,
// with round-robin fairness, an acknowledge timeout and a saturating count of dropped words.
module rx_fifo_arbiter #(
    parameter int DATA_BITS   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 FIFO_Empty,
    input  logic [DATA_BITS-1:0] FIFO_Data,
    output logic                 Read_Done,
    input  logic                 BIST_Mode,
    input  logic                 Host_Req,
    input  logic                 BIST_Req,
    input  logic                 Host_Ack,
    input  logic                 BIST_Ack,
    output logic                 Host_Valid,
    output logic                 BIST_Valid,
    output logic [DATA_BITS-1:0] Host_Data,
    output logic [DATA_BITS-1:0] BIST_Data,
    output logic [7:0]           Drop_Count,
    output logic                 Busy
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic       winner_reg, winner_next;   // 0 = Host, 1 = BIST
    logic       last_reg, last_next;       // requester granted most recently
    logic [7:0] timer_reg, timer_next;
    logic [7:0] drop_reg, drop_next;

    logic [1:0] req_vec;
    logic [1:0] ack_vec;
    logic       pick;
    logic       winner_ack;
    logic       capture_evt;
    logic       release_evt;

    // Bit 0 is the Host slot, bit 1 the BIST slot; BIST_Mode masks the Host request.
    assign req_vec    = {BIST_Req, Host_Req & ~BIST_Mode};
    assign ack_vec    = {BIST_Ack, Host_Ack};
    assign winner_ack = ack_vec[winner_reg];
    assign pick       = (req_vec == 2'b11) ? ~last_reg : req_vec[1];

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg  <= S_IDLE;
            winner_reg <= 1'b0;
            last_reg   <= 1'b1;
            timer_reg  <= 8'd0;
            drop_reg   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            last_reg   <= last_next;
            timer_reg  <= timer_next;
            drop_reg   <= drop_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        last_next   = last_reg;
        timer_next  = timer_reg;
        drop_next   = drop_reg;
        case (state_reg)
            S_IDLE: begin
                if (!FIFO_Empty && (req_vec != 2'b00)) begin
                    winner_next = pick;
                    last_next   = pick;
                    state_next  = S_POP;
                end
            end
            S_POP: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                timer_next = TIMEOUT_LOAD;
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (winner_ack) begin
                    state_next = S_IDLE;
                end else if (timer_reg <= 8'd1) begin
                    // Ack in this same cycle would have won above, so this is a genuine drop.
                    state_next = S_IDLE;
                    if (drop_reg != 8'hFF) begin
                        drop_next = drop_reg + 8'd1;
                    end
                end else begin
                    timer_next = timer_reg - 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        Read_Done   = 1'b0;
        Busy        = 1'b0;
        capture_evt = 1'b0;
        release_evt = 1'b0;
        case (state_reg)
            S_IDLE: begin
                Busy = 1'b0;
            end
            S_POP: begin
                Read_Done = 1'b1;
                Busy      = 1'b1;
            end
            S_CAPTURE: begin
                Busy        = 1'b1;
                capture_evt = 1'b1;
            end
            S_HOLD: begin
                Busy        = 1'b1;
                release_evt = winner_ack || (timer_reg <= 8'd1);
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // Per-requester presentation registers; slot 0 is Host, slot 1 is BIST.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic                 valid_reg;
        logic [DATA_BITS-1:0] data_reg;
        logic                 is_winner;

        assign is_winner = (winner_reg == 1'(gi));

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (capture_evt && is_winner) begin
                valid_reg <= 1'b1;
                data_reg  <= FIFO_Data;
            end else if (release_evt && is_winner) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign Host_Valid = g_req[0].valid_reg;
    assign BIST_Valid = g_req[1].valid_reg;
    assign Host_Data  = g_req[0].data_reg;
    assign BIST_Data  = g_req[1].data_reg;
    assign Drop_Count = drop_reg;

    a_one_valid : assert property (@(posedge Clk) disable iff (!Rst_n)
        !(Host_Valid && BIST_Valid));

    a_no_pop_when_empty : assert property (@(posedge Clk) disable iff (!Rst_n)
        (state_reg == S_IDLE && FIFO_Empty) |=> (state_reg != S_POP));

endmodule
